stack_cmd_sequencer: RTL and testbench

STACK_CMD_SEQUENCER -- requirements
Module: stack_cmd_sequencer

---
 rtl/stack_pkg.sv | 21 ++
 rtl/stack_occ_tracker.sv | 49 ++++
 rtl/stack_cmd_sequencer.sv | 151 +++++++++++++++
 tb/tb_stack_cmd_sequencer.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/stack_pkg.sv
// Shared constants and enums for the stack command sequencer.
package stack_pkg;

    localparam int unsigned DEPTH = 5;
    localparam int unsigned DW    = 4;
    localparam int unsigned IW    = 3;

    typedef enum logic [1:0] {
        CMD_NOP  = 2'b00,
        CMD_POP  = 2'b01,
        CMD_PUSH = 2'b10,
        CMD_GET  = 2'b11
    } cmd_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_RESP  = 2'b10
    } state_e;

endpackage

// File: rtl/stack_occ_tracker.sv
// Tracks stack occupancy and judges whether a command is legal at the current count.
module stack_occ_tracker #(
    parameter int unsigned DEPTH = 5,
    parameter int unsigned IW    = 3,
    parameter int unsigned CW    = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [1:0]    cmd,
    input  logic [IW-1:0] index,
    input  logic          commit,
    output logic [CW-1:0] count,
    output logic          legal
);
    import stack_pkg::*;

    logic [CW-1:0] count_q, count_d;
    cmd_e          cmd_s;

    assign cmd_s = cmd_e'(cmd);
    assign count = count_q;

    always_comb begin
        legal = 1'b1;
        case (cmd_s)
            CMD_PUSH: legal = (32'(count_q) < DEPTH);
            CMD_POP:  legal = (count_q != '0);
            CMD_GET:  legal = (32'(index) < 32'(count_q));
            default:  legal = 1'b1;
        endcase
    end

    // Saturating update keeps the count inside 0..DEPTH even on a bad commit.
    always_comb begin
        count_d = count_q;
        if (commit) begin
            if (cmd_s == CMD_PUSH && 32'(count_q) < DEPTH)
                count_d = count_q + 1'b1;
            else if (cmd_s == CMD_POP && count_q != '0)
                count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) count_q <= '0;
        else        count_q <= count_d;
    end

endmodule

// File: rtl/stack_cmd_sequencer.sv
// Accepts stack requests, issues one registered command per legal request, returns a held response.
module stack_cmd_sequencer #(
    parameter int unsigned DEPTH = 5,
    parameter int unsigned DW    = 4,
    parameter int unsigned IW    = 3
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [1:0]    req_cmd,
    input  logic [IW-1:0] req_index,
    input  logic [DW-1:0] req_data,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_data,
    output logic          rsp_err,
    output logic [1:0]    stk_command,
    output logic [IW-1:0] stk_index,
    output logic [DW-1:0] stk_data_out,
    output logic          stk_data_oe,
    input  logic [DW-1:0] stk_data_in,
    output logic          stk_reset,
    output logic [2:0]    occupancy
);
    import stack_pkg::*;

    localparam int unsigned CW = $clog2(DEPTH + 1);

    state_e        state_q, state_d;
    cmd_e          cmd_q, cmd_d;
    logic [1:0]    stk_cmd_q, stk_cmd_d;
    logic [IW-1:0] stk_idx_q, stk_idx_d;
    logic [DW-1:0] stk_dout_q, stk_dout_d;
    logic          stk_oe_q, stk_oe_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [DW-1:0] rsp_data_q, rsp_data_d;
    logic          rsp_err_q, rsp_err_d;
    logic          stk_reset_q;

    logic [1:0]    trk_cmd;
    logic          trk_commit;
    logic [CW-1:0] trk_count;
    logic          trk_legal;
    cmd_e          req_cmd_s;

    assign req_cmd_s = cmd_e'(req_cmd);

    stack_occ_tracker #(
        .DEPTH (DEPTH),
        .IW    (IW),
        .CW    (CW)
    ) u_occ (
        .clk    (CLK),
        .rst_n  (RESET),
        .cmd    (trk_cmd),
        .index  (req_index),
        .commit (trk_commit),
        .count  (trk_count),
        .legal  (trk_legal)
    );

    assign req_ready    = (state_q == ST_IDLE) && RESET;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_data     = rsp_data_q;
    assign rsp_err      = rsp_err_q;
    assign stk_command  = stk_cmd_q;
    assign stk_index    = stk_idx_q;
    assign stk_data_out = stk_dout_q;
    assign stk_data_oe  = stk_oe_q;
    assign stk_reset    = stk_reset_q;
    assign occupancy    = 3'(trk_count);

    // The tracker sees the live request while idle (legality) and the latched command while issuing (commit).
    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        stk_cmd_d   = CMD_NOP;
        stk_idx_d   = '0;
        stk_dout_d  = '0;
        stk_oe_d    = 1'b0;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        trk_cmd     = req_cmd;
        trk_commit  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready) begin
                    cmd_d = req_cmd_s;
                    if (req_cmd_s == CMD_NOP || !trk_legal) begin
                        state_d     = ST_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = !trk_legal;
                        rsp_data_d  = '0;
                    end else begin
                        state_d    = ST_ISSUE;
                        stk_cmd_d  = req_cmd;
                        stk_idx_d  = (req_cmd_s == CMD_GET) ? req_index : '0;
                        stk_oe_d   = (req_cmd_s == CMD_PUSH);
                        stk_dout_d = (req_cmd_s == CMD_PUSH) ? req_data : '0;
                    end
                end
            end
            ST_ISSUE: begin
                trk_cmd     = cmd_q;
                trk_commit  = 1'b1;
                state_d     = ST_RESP;
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b0;
                rsp_data_d  = (cmd_q == CMD_PUSH) ? '0 : stk_data_in;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b0;
                    rsp_data_d  = '0;
                    rsp_err_d   = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        stk_reset_q <= !RESET;
        if (!RESET) begin
            state_q     <= ST_IDLE;
            cmd_q       <= CMD_NOP;
            stk_cmd_q   <= '0;
            stk_idx_q   <= '0;
            stk_dout_q  <= '0;
            stk_oe_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            stk_cmd_q   <= stk_cmd_d;
            stk_idx_q   <= stk_idx_d;
            stk_dout_q  <= stk_dout_d;
            stk_oe_q    <= stk_oe_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

endmodule

// File: tb/tb_stack_cmd_sequencer.sv
// Directed bench for stack_cmd_sequencer; a queue-based stack model sets per-cycle expectations.
module tb_stack_cmd_sequencer;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_cmd;
    logic [2:0] req_index;
    logic [3:0] req_data;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [3:0] rsp_data;
    logic       rsp_err;
    logic [1:0] stk_command;
    logic [2:0] stk_index;
    logic [3:0] stk_data_out;
    logic       stk_data_oe;
    logic [3:0] stk_data_in;
    logic       stk_reset;
    logic [2:0] occupancy;

    stack_cmd_sequencer #(.DEPTH(5), .DW(4), .IW(3)) dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_cmd      (req_cmd),
        .req_index    (req_index),
        .req_data     (req_data),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_data     (rsp_data),
        .rsp_err      (rsp_err),
        .stk_command  (stk_command),
        .stk_index    (stk_index),
        .stk_data_out (stk_data_out),
        .stk_data_oe  (stk_data_oe),
        .stk_data_in  (stk_data_in),
        .stk_reset    (stk_reset),
        .occupancy    (occupancy)
    );

    always #5 CLK = ~CLK;

    int n_pass = 0;
    int n_total = 0;
    bit chk_en = 1'b0;

    int e_ready, e_rv, e_rd, e_re, e_cmd, e_idx, e_oe, e_dout, e_srst, e_occ;
    int last_rd, last_re;
    int stk[$];

    task automatic ck(input string name, input int act, input int exp);
        n_total++;
        if (act != exp) $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        else n_pass++;
    endtask

    always @(posedge CLK) begin
        #1;
        if (chk_en) begin
            ck("req_ready",   req_ready,   e_ready);
            ck("rsp_valid",   rsp_valid,   e_rv);
            ck("rsp_data",    rsp_data,    e_rd);
            ck("rsp_err",     rsp_err,     e_re);
            ck("stk_command", stk_command, e_cmd);
            ck("stk_index",   stk_index,   e_idx);
            ck("stk_data_oe", stk_data_oe, e_oe);
            if (e_oe != 0) ck("stk_data_out", stk_data_out, e_dout);
            ck("stk_reset",   stk_reset,   e_srst);
            ck("occupancy",   occupancy,   e_occ);
            if (rsp_valid) begin
                last_rd = rsp_data;
                last_re = rsp_err;
            end
        end
    end

    task automatic set_idle_exp();
        e_ready = 1; e_rv = 0; e_rd = 0; e_re = 0;
        e_cmd = 0; e_idx = 0; e_oe = 0; e_dout = 0; e_srst = 0;
        e_occ = stk.size();
    endtask

    task automatic set_reset_exp();
        stk.delete();
        e_ready = 0; e_rv = 0; e_rd = 0; e_re = 0;
        e_cmd = 0; e_idx = 0; e_oe = 0; e_dout = 0; e_srst = 1; e_occ = 0;
    endtask

    // Every task starts and ends just after a falling edge.
    task automatic do_reset();
        RESET = 1'b0;
        set_reset_exp();
        @(negedge CLK);
        RESET = 1'b1;
        set_idle_exp();
        @(negedge CLK);
    endtask

    task automatic xact(input int cmd, input int idx, input int data, input int hold);
        bit legal;
        bit issued;
        int val;
        case (cmd)
            1:       legal = stk.size() > 0;
            2:       legal = stk.size() < 5;
            3:       legal = idx < stk.size();
            default: legal = 1'b1;
        endcase
        issued = legal && cmd != 0;
        req_valid = 1'b1;
        req_cmd   = 2'(cmd);
        req_index = 3'(idx);
        req_data  = 4'(data);
        e_ready = 0;
        if (!issued) begin
            e_rv = 1; e_re = legal ? 0 : 1; e_rd = 0;
        end else begin
            e_cmd = cmd;
            e_idx = (cmd == 3) ? idx : 0;
            e_oe  = (cmd == 2) ? 1 : 0;
            e_dout = data;
        end
        @(negedge CLK);
        req_valid = 1'b0;
        if (issued) begin
            val = 0;
            if (cmd == 1) val = stk[stk.size()-1];
            if (cmd == 3) val = stk[stk.size()-1-idx];
            stk_data_in = (cmd == 2) ? 4'hC : 4'(val);
            e_cmd = 0; e_idx = 0; e_oe = 0; e_dout = 0;
            e_rv = 1; e_re = 0; e_rd = (cmd == 2) ? 0 : val;
            if (cmd == 2) stk.push_back(data);
            if (cmd == 1) void'(stk.pop_back());
            e_occ = stk.size();
            @(negedge CLK);
            stk_data_in = ~stk_data_in;
        end
        // A competing request stays offered while the response is held and released.
        req_valid = 1'b1;
        req_cmd   = 2'b10;
        req_data  = 4'hF;
        repeat (hold) @(negedge CLK);
        rsp_ready = 1'b1;
        set_idle_exp();
        @(negedge CLK);
        rsp_ready = 1'b0;
        req_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET = 1'b0; req_valid = 1'b0; req_cmd = '0; req_index = '0;
        req_data = '0; rsp_ready = 1'b0; stk_data_in = 4'h0;
        last_rd = -1; last_re = -1;
        set_reset_exp();
        @(negedge CLK);
        chk_en = 1'b1;
        @(negedge CLK);
        RESET = 1'b1;
        set_idle_exp();
        @(negedge CLK);

        xact(2, 0, 4'h3, 0);
        xact(2, 0, 4'h7, 0);
        xact(2, 0, 4'hA, 0);
        ck("lit_occ_after_3push", occupancy, 3);

        xact(3, 2, 0, 0);
        ck("lit_get2_data", last_rd, 3);
        ck("lit_get2_occ", occupancy, 3);
        xact(1, 0, 0, 0);
        ck("lit_pop_data", last_rd, 10);
        ck("lit_pop_occ", occupancy, 2);
        xact(3, 7, 0, 0);
        ck("lit_get7_err", last_re, 1);

        do_reset();
        for (int i = 1; i <= 5; i++) xact(2, 0, i, 0);
        xact(2, 0, 4'hF, 0);
        ck("lit_ovf_err", last_re, 1);
        ck("lit_ovf_occ", occupancy, 5);
        xact(3, 4, 0, 0);
        ck("lit_get4_data", last_rd, 1);

        do_reset();
        xact(1, 0, 0, 0);
        ck("lit_unf_pop_err", last_re, 1);
        xact(3, 0, 0, 0);
        ck("lit_unf_get_err", last_re, 1);
        ck("lit_unf_occ", occupancy, 0);
        xact(0, 0, 0, 0);
        ck("lit_nop_err", last_re, 0);

        xact(2, 0, 4'h9, 0);
        xact(2, 0, 4'h6, 0);
        xact(1, 0, 0, 4);
        ck("lit_hold_pop_data", last_rd, 6);
        ck("lit_hold_occ", occupancy, 1);

        do_reset();
        xact(2, 0, 4'h1, 0);
        xact(2, 0, 4'h2, 0);
        req_valid = 1'b1; req_cmd = 2'b10; req_data = 4'h5;
        e_ready = 0; e_cmd = 2; e_idx = 0; e_oe = 1; e_dout = 5;
        @(negedge CLK);
        req_valid = 1'b0;
        RESET = 1'b0;
        set_reset_exp();
        @(negedge CLK);
        RESET = 1'b1;
        set_idle_exp();
        @(negedge CLK);
        @(negedge CLK);
        ck("lit_rst_issue_occ", occupancy, 0);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
